// File: rtl/gobou_net_loader.sv
`default_nettype none
// ============================================================================
//  Module      : gobou_net_loader
//  Description : Write-side initiator for the gobou per-core weight memories.
//                Accepts a weight/bias word stream (valid/ready) and drives the
//                gobou net write port, placing output neuron o on core
//                (o mod GOBOU_CORE). Pulses done once every word is written.
//                Optional macro GOBOU_NET_LOADER_ERR_EN adds a sticky err
//                output flagging writes whose address wrapped.
//  Revision    : 1.0 - initial release
// ============================================================================
module gobou_net_loader #(
    parameter int DWIDTH        = 16,
    parameter int LWIDTH        = 10,
    parameter int GOBOU_CORE    = 16,
    parameter int GOBOU_CORELOG = 4,
    parameter int GOBOU_NETSIZE = 11
) (
    input  logic                       clk,
    input  logic                       xrst,
    input  logic                       start,
    input  logic [LWIDTH-1:0]          total_out,
    input  logic [LWIDTH-1:0]          total_in,
    input  logic [GOBOU_NETSIZE-1:0]   net_offset,
    input  logic                       s_valid,
    input  logic signed [DWIDTH-1:0]   s_data,
    output logic                       s_ready,
    output logic [GOBOU_CORELOG-1:0]   net_sel,
    output logic                       net_we,
    output logic [GOBOU_NETSIZE-1:0]   net_addr,
    output logic signed [DWIDTH-1:0]   net_wdata,
    output logic                       busy,
    output logic                       done
`ifdef GOBOU_NET_LOADER_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam logic [GOBOU_CORELOG-1:0] c_CORE_MAX = GOBOU_CORELOG'(GOBOU_CORE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [LWIDTH-1:0]          r_total_out;
    logic [LWIDTH-1:0]          r_total_in;
    logic [LWIDTH-1:0]          r_idx;
    logic [LWIDTH-1:0]          r_neuron;
    logic [GOBOU_CORELOG-1:0]   r_core;
    // r_base tracks net_offset + round*(total_in+1); advancing it once per
    // round replaces the multiplier the address formula would otherwise need.
    logic [GOBOU_NETSIZE-1:0]   r_base;

    logic                       w_start_ok;
    logic                       w_start_zero;
    logic                       w_xfer;
    logic                       w_idx_last;
    logic                       w_round_end;
    logic                       w_last;
    logic [GOBOU_NETSIZE-1:0]   w_addr;
    logic [GOBOU_NETSIZE-1:0]   w_base_next;

    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_start_zero = (total_out == '0) || (total_in == '0);
    // s_ready is only ever high in S_LOAD, so a transfer implies S_LOAD.
    assign w_xfer       = s_valid && s_ready;
    assign w_idx_last   = (r_idx == r_total_in);
    assign w_round_end  = w_idx_last && (r_core == c_CORE_MAX);
    assign w_last       = w_xfer && w_idx_last && (r_neuron == (r_total_out - LWIDTH'(1)));
    assign busy         = (r_state != S_IDLE);

`ifdef GOBOU_NET_LOADER_ERR_EN
    // Wide enough that neither sum below can overflow, so the upper bits
    // reveal whether the true address left the memory range.
    localparam int c_SW = GOBOU_NETSIZE + LWIDTH + 1;

    logic [c_SW-1:0]            w_addr_full;
    logic [c_SW-1:0]            w_base_full;
    logic                       w_addr_carry;
    logic                       w_base_carry;
    logic                       r_base_ovf;

    assign w_addr_full  = c_SW'(r_base) + c_SW'(r_idx);
    assign w_base_full  = c_SW'(r_base) + c_SW'(r_total_in) + c_SW'(1);
    assign w_addr       = w_addr_full[GOBOU_NETSIZE-1:0];
    assign w_base_next  = w_base_full[GOBOU_NETSIZE-1:0];
    assign w_addr_carry = |w_addr_full[c_SW-1:GOBOU_NETSIZE];
    assign w_base_carry = |w_base_full[c_SW-1:GOBOU_NETSIZE];

    // Sticky wrap detection: once the round base wraps, every later write of
    // this load is out of range even though its wrapped sum looks small.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            err        <= 1'b0;
            r_base_ovf <= 1'b0;
        end else if (w_start_ok) begin
            err        <= 1'b0;
            r_base_ovf <= 1'b0;
        end else begin
            if (w_xfer && w_round_end && w_base_carry) begin
                r_base_ovf <= 1'b1;
            end
            if (w_xfer && (r_base_ovf || w_addr_carry)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign w_addr      = r_base + GOBOU_NETSIZE'(r_idx);
    assign w_base_next = r_base + GOBOU_NETSIZE'(r_total_in) + GOBOU_NETSIZE'(1);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: zero-sized loads skip straight to the done pulse.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_start_zero ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Config latch, stream counters and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_total_out <= '0;
            r_total_in  <= '0;
            r_idx       <= '0;
            r_neuron    <= '0;
            r_core      <= '0;
            r_base      <= '0;
            s_ready     <= 1'b0;
            net_we      <= 1'b0;
            net_sel     <= '0;
            net_addr    <= '0;
            net_wdata   <= '0;
            done        <= 1'b0;
        end else begin
            net_we <= 1'b0;
            done   <= 1'b0;
            if (w_start_ok) begin
                r_total_out <= total_out;
                r_total_in  <= total_in;
                r_idx       <= '0;
                r_neuron    <= '0;
                r_core      <= '0;
                r_base      <= net_offset;
                s_ready     <= !w_start_zero;
                done        <= w_start_zero;
            end
            if (w_xfer) begin
                net_we    <= 1'b1;
                net_sel   <= r_core;
                net_addr  <= w_addr;
                net_wdata <= s_data;
                if (w_idx_last) begin
                    r_idx    <= '0;
                    r_neuron <= r_neuron + LWIDTH'(1);
                    if (r_core == c_CORE_MAX) begin
                        r_core <= '0;
                        r_base <= w_base_next;
                    end else begin
                        r_core <= r_core + GOBOU_CORELOG'(1);
                    end
                end else begin
                    r_idx <= r_idx + LWIDTH'(1);
                end
                // Done lands in the same cycle as the final write strobe.
                if (w_last) begin
                    s_ready <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gobou_net_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gobou_net_loader
//  Description : Self-checking bench for gobou_net_loader (table-driven
//                cycle vectors plus hand-written multi-cycle sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gobou_net_loader;

    logic               clk = 1'b0;
    logic               xrst;
    logic               start;
    logic [9:0]         total_out;
    logic [9:0]         total_in;
    logic [10:0]        net_offset;
    logic               s_valid;
    logic signed [15:0] s_data;
    logic               s_ready;
    logic [3:0]         net_sel;
    logic               net_we;
    logic [10:0]        net_addr;
    logic signed [15:0] net_wdata;
    logic               busy;
    logic               done;
`ifdef GOBOU_NET_LOADER_ERR_EN
    logic               err;
`endif

    int checks   = 0;
    int failures = 0;

    gobou_net_loader dut (
        .clk        (clk),
        .xrst       (xrst),
        .start      (start),
        .total_out  (total_out),
        .total_in   (total_in),
        .net_offset (net_offset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .net_sel    (net_sel),
        .net_we     (net_we),
        .net_addr   (net_addr),
        .net_wdata  (net_wdata),
        .busy       (busy),
        .done       (done)
`ifdef GOBOU_NET_LOADER_ERR_EN
        ,
        .err        (err)
`endif
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [9:0]  tot_out;
        logic [9:0]  tot_in;
        logic [10:0] offset;
        logic        valid;
        logic [15:0] data;
        logic        e_ready;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [10:0] e_addr;
        logic [15:0] e_data;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, input int to, input int ti, input int off,
                       input logic v, input int d, input logic er, input logic ew,
                       input int es, input int ea, input int ed,
                       input logic eb, input logic edn);
        vec_t r;
        r.start = st;      r.tot_out = 10'(to); r.tot_in = 10'(ti); r.offset = 11'(off);
        r.valid = v;       r.data    = 16'(d);  r.e_ready = er;     r.e_we   = ew;
        r.e_sel = 4'(es);  r.e_addr  = 11'(ea); r.e_data  = 16'(ed);
        r.e_busy = eb;     r.e_done  = edn;
        vq.push_back(r);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; s_valid = 1'b0; s_data = '0;
    endtask

    initial begin
        // ------------------------------------------------------------------
        // Vector table: inputs held for one edge, outputs checked just after.
        // ------------------------------------------------------------------
        // T2: 2 neurons x (3 weights + bias), offset 0, back-to-back stream.
        add(1, 2, 3, 0,  0, 0,   1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0,  1, 1,   1, 1, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0,  1, 2,   1, 1, 0, 1, 2, 1, 0);
        add(0, 0, 0, 0,  1, 3,   1, 1, 0, 2, 3, 1, 0);
        add(0, 0, 0, 0,  1, 4,   1, 1, 0, 3, 4, 1, 0);
        add(0, 0, 0, 0,  1, 5,   1, 1, 1, 0, 5, 1, 0);
        add(0, 0, 0, 0,  1, 6,   1, 1, 1, 1, 6, 1, 0);
        add(0, 0, 0, 0,  1, 7,   1, 1, 1, 2, 7, 1, 0);
        add(0, 0, 0, 0,  1, 8,   0, 1, 1, 3, 8, 1, 1);
        add(0, 0, 0, 0,  1, 99,  0, 0, 0, 0, 0, 0, 0);
        // T4: gapped stream; a start during the gap must be ignored.
        add(1, 1, 3, 10, 0, 0,   1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0,  1, 10,  1, 1, 0, 10, 10, 1, 0);
        add(1, 5, 0, 0,  0, 55,  1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0,  1, 11,  1, 1, 0, 11, 11, 1, 0);
        add(0, 0, 0, 0,  0, 66,  1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0,  1, 12,  1, 1, 0, 12, 12, 1, 0);
        add(0, 0, 0, 0,  1, 13,  0, 1, 0, 13, 13, 1, 1);
        add(0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0);
        // T5: zero-sized loads pulse done without any write.
        add(1, 3, 0, 0,  1, 7,   0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0,  1, 7,   0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4, 0,  0, 0,   0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        idle_inputs();
        total_out = '0; total_in = '0; net_offset = '0;
        xrst = 1'b0;
        step(); step();
        chk("rst_ready", int'(s_ready), 0);
        chk("rst_we",    int'(net_we), 0);
        chk("rst_sel",   int'(net_sel), 0);
        chk("rst_addr",  int'(net_addr), 0);
        chk("rst_data",  int'(net_wdata), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
`ifdef GOBOU_NET_LOADER_ERR_EN
        chk("rst_err",   int'(err), 0);
`endif
        xrst = 1'b1;
        step();

        // Apply the table.
        foreach (vq[i]) begin
            start = vq[i].start; total_out = vq[i].tot_out; total_in = vq[i].tot_in;
            net_offset = vq[i].offset; s_valid = vq[i].valid; s_data = vq[i].data;
            step();
            chk($sformatf("v%0d_ready", i), int'(s_ready), int'(vq[i].e_ready));
            chk($sformatf("v%0d_we",    i), int'(net_we),  int'(vq[i].e_we));
            chk($sformatf("v%0d_busy",  i), int'(busy),    int'(vq[i].e_busy));
            chk($sformatf("v%0d_done",  i), int'(done),    int'(vq[i].e_done));
            if (vq[i].e_we) begin
                chk($sformatf("v%0d_sel",  i), int'(net_sel),  int'(vq[i].e_sel));
                chk($sformatf("v%0d_addr", i), int'(net_addr), int'(vq[i].e_addr));
                chk($sformatf("v%0d_data", i), int'(net_wdata), int'(vq[i].e_data));
            end
        end
        idle_inputs();

        // T3: 17 neurons, 1 input, offset 5; neuron 16 wraps back to core 0.
        start = 1'b1; total_out = 10'd17; total_in = 10'd1; net_offset = 11'd5;
        step();
        start = 1'b0;
        for (int k = 0; k < 34; k++) begin
            int o, ix;
            o  = k / 2;
            ix = k % 2;
            s_valid = 1'b1; s_data = 16'(k + 100);
            step();
            chk($sformatf("t3_we%0d",   k), int'(net_we), 1);
            chk($sformatf("t3_sel%0d",  k), int'(net_sel), o % 16);
            chk($sformatf("t3_addr%0d", k), int'(net_addr), 5 + (o / 16) * 2 + ix);
            chk($sformatf("t3_data%0d", k), int'(net_wdata), k + 100);
            chk($sformatf("t3_done%0d", k), int'(done), (k == 33) ? 1 : 0);
        end
        s_valid = 1'b0;
        step();
        chk("t3_idle_busy", int'(busy), 0);

        // T1: reset in the middle of a load abandons it.
        start = 1'b1; total_out = 10'd4; total_in = 10'd3; net_offset = 11'd0;
        step();
        start = 1'b0; s_valid = 1'b1; s_data = 16'd21;
        step(); step();
        chk("t1_pre_we", int'(net_we), 1);
        xrst = 1'b0;
        step();
        chk("t1_we",    int'(net_we), 0);
        chk("t1_ready", int'(s_ready), 0);
        chk("t1_busy",  int'(busy), 0);
        chk("t1_done",  int'(done), 0);
        xrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t1_post_we%0d", k), int'(net_we), 0);
            chk($sformatf("t1_post_ready%0d", k), int'(s_ready), 0);
        end
        s_valid = 1'b0;

        // T6: addresses wrap past the top of the net memory.
        start = 1'b1; total_out = 10'd1; total_in = 10'd7; net_offset = 11'd2044;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1; s_data = 16'(200 + k);
            step();
            chk($sformatf("t6_we%0d",   k), int'(net_we), 1);
            chk($sformatf("t6_addr%0d", k), int'(net_addr), (2044 + k) % 2048);
            chk($sformatf("t6_done%0d", k), int'(done), (k == 7) ? 1 : 0);
`ifdef GOBOU_NET_LOADER_ERR_EN
            chk($sformatf("t6_err%0d",  k), int'(err), (k >= 4) ? 1 : 0);
`endif
        end
        s_valid = 1'b0;
        step();
        // A fresh start clears the sticky flag.
        start = 1'b1; total_out = 10'd1; total_in = 10'd1; net_offset = 11'd0;
        step();
        start = 1'b0;
        chk("t6_restart_ready", int'(s_ready), 1);
`ifdef GOBOU_NET_LOADER_ERR_EN
        chk("t6_err_clear", int'(err), 0);
`endif
        s_valid = 1'b1; s_data = 16'd1;
        step();
        s_data = 16'd2;
        step();
        chk("t6_tail_done", int'(done), 1);
        chk("t6_tail_addr", int'(net_addr), 1);
        s_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
